// File: rtl/fir_avg_pkg.sv
// rtl/fir_avg_pkg.sv - shared types and width helpers for the moving-window FIR block
//   mode_e    : per-sample result mode (AVG, SUM_SAT, MAX, PASS)
//   log2_ceil : ceiling log2 for elaboration-time widths
//   w_sum     : width of the exact window sum for a given sample width and tap count
package fir_avg_pkg;

  typedef enum logic [1:0] {
    AVG     = 2'd0,
    SUM_SAT = 2'd1,
    MAX     = 2'd2,
    PASS    = 2'd3
  } mode_e;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Summing N_TAPS unsigned W_DATA-bit samples needs log2(N_TAPS) extra bits.
  function automatic int w_sum(input int w_data, input int n_taps);
    return w_data + log2_ceil(n_taps);
  endfunction

endpackage

// File: rtl/fir_avg_stage.sv
// rtl/fir_avg_stage.sv - one add/max pipeline stage operating on tap K of its own window copy
//   clk_i, rst_i          : clock, synchronous active-high reset
//   valid_i/valid_o       : stage occupancy bit
//   mode_i/mode_o         : result mode captured with the sample
//   win_i/win_o           : full window snapshot travelling with the sample
//   sum_i/sum_o           : running sum of taps 0..K-1 in, 0..K out
//   max_i/max_o           : running max of taps 0..K-1 in, 0..K out
module fir_avg_stage
  import fir_avg_pkg::*;
#(
  parameter int W_DATA = 8,
  parameter int N_TAPS = 4,
  parameter int W_SUM  = 10,
  parameter int K      = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           valid_i,
  input  mode_e                          mode_i,
  input  logic [N_TAPS-1:0][W_DATA-1:0]  win_i,
  input  logic [W_SUM-1:0]               sum_i,
  input  logic [W_DATA-1:0]              max_i,
  output logic                           valid_o,
  output mode_e                          mode_o,
  output logic [N_TAPS-1:0][W_DATA-1:0]  win_o,
  output logic [W_SUM-1:0]               sum_o,
  output logic [W_DATA-1:0]              max_o
);

  logic [W_DATA-1:0]             tap;
  logic [W_SUM-1:0]              sum_d;
  logic [W_DATA-1:0]             max_d;

  logic                          valid_q;
  mode_e                         mode_q;
  logic [N_TAPS-1:0][W_DATA-1:0] win_q;
  logic [W_SUM-1:0]              sum_q;
  logic [W_DATA-1:0]             max_q;

  assign tap = win_i[K];

  always_comb begin
    sum_d = sum_i + W_SUM'(tap);
    max_d = (tap > max_i) ? tap : max_i;
  end

  // The stage advances every clock; a bubble simply propagates with valid low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      mode_q  <= AVG;
      win_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
    end else begin
      valid_q <= valid_i;
      mode_q  <= mode_i;
      win_q   <= win_i;
      sum_q   <= sum_d;
      max_q   <= max_d;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign win_o   = win_q;
  assign sum_o   = sum_q;
  assign max_o   = max_q;

endmodule

// File: rtl/fir_avg_pipeline.sv
// rtl/fir_avg_pipeline.sv - moving-window sum/average/max filter with fixed N_TAPS+1 latency
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : sample strobe, no backpressure
//   in_data      : unsigned sample
//   mode         : result mode sampled with in_data (0 AVG, 1 SUM_SAT, 2 MAX, 3 PASS)
//   clear        : synchronous window flush
//   out_valid    : one-cycle strobe per accepted sample
//   out_data     : mode-dependent result, held between strobes
//   out_sum      : exact window sum, held between strobes
//   window_full  : registered, high once N_TAPS samples accepted since reset/clear
module fir_avg_pipeline
  import fir_avg_pkg::*;
#(
  parameter int W_DATA = 8,
  parameter int N_TAPS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [W_DATA-1:0]                    in_data,
  input  logic [1:0]                           mode,
  input  logic                                 clear,
  output logic                                 out_valid,
  output logic [W_DATA-1:0]                    out_data,
  output logic [w_sum(W_DATA, N_TAPS)-1:0]     out_sum,
  output logic                                 window_full
);

  localparam int LOG_N = log2_ceil(N_TAPS);
  localparam int W_SUM = w_sum(W_DATA, N_TAPS);
  localparam int W_CNT = LOG_N + 1;
  localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(N_TAPS);

  // ---------------------------------------------------------------------
  // Window and fill counter
  // ---------------------------------------------------------------------
  logic [N_TAPS-1:0][W_DATA-1:0] window_q, window_d, window_base;
  logic [W_CNT-1:0]              cnt_q, cnt_d, cnt_base;
  logic                          full_q, full_d;

  // clear acts first so that clear+in_valid lands as {in_data, 0, ..., 0}
  // with a fill count of one.
  always_comb begin
    window_base = clear ? '0 : window_q;
    window_d    = window_base;
    if (in_valid) begin
      window_d[0] = in_data;
      for (int i = 1; i < N_TAPS; i++) begin
        window_d[i] = window_base[i-1];
      end
    end
  end

  always_comb begin
    cnt_base = clear ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (in_valid && (cnt_base != CNT_MAX)) begin
      cnt_d = cnt_base + 1'b1;
    end
    full_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      window_q <= window_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end

  assign window_full = full_q;

  // ---------------------------------------------------------------------
  // Capture register: a private snapshot of the updated window and mode
  // enters the pipeline, so later shifts or clears cannot touch it.
  // ---------------------------------------------------------------------
  logic                          cap_valid_q;
  mode_e                         cap_mode_q;
  logic [N_TAPS-1:0][W_DATA-1:0] cap_win_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid_q <= 1'b0;
      cap_mode_q  <= AVG;
      cap_win_q   <= '0;
    end else begin
      cap_valid_q <= in_valid;
      if (in_valid) begin
        cap_mode_q <= mode_e'(mode);
        cap_win_q  <= window_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Add/max chain: stage k folds tap k into the running sum and max.
  // ---------------------------------------------------------------------
  logic [N_TAPS:0]               st_valid;
  mode_e                         st_mode [N_TAPS+1];
  logic [N_TAPS-1:0][W_DATA-1:0] st_win  [N_TAPS+1];
  logic [W_SUM-1:0]              st_sum  [N_TAPS+1];
  logic [W_DATA-1:0]             st_max  [N_TAPS+1];

  assign st_valid[0] = cap_valid_q;
  assign st_mode[0]  = cap_mode_q;
  assign st_win[0]   = cap_win_q;
  assign st_sum[0]   = '0;
  assign st_max[0]   = '0;

  for (genvar k = 0; k < N_TAPS; k++) begin : g_stage
    fir_avg_stage #(
      .W_DATA (W_DATA),
      .N_TAPS (N_TAPS),
      .W_SUM  (W_SUM),
      .K      (k)
    ) u_stage (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (st_valid[k]),
      .mode_i  (st_mode[k]),
      .win_i   (st_win[k]),
      .sum_i   (st_sum[k]),
      .max_i   (st_max[k]),
      .valid_o (st_valid[k+1]),
      .mode_o  (st_mode[k+1]),
      .win_o   (st_win[k+1]),
      .sum_o   (st_sum[k+1]),
      .max_o   (st_max[k+1])
    );
  end

  // Only the newest tap is needed past the last stage (PASS mode).
  logic unused_win_tail;
  assign unused_win_tail = ^st_win[N_TAPS][N_TAPS-1:1];

  // ---------------------------------------------------------------------
  // Output register: result selection by the mode that travelled with the
  // sample; outputs hold their value between strobes.
  // ---------------------------------------------------------------------
  logic                 out_valid_q, out_valid_d;
  logic [W_DATA-1:0]    out_data_q,  out_data_d;
  logic [W_SUM-1:0]     out_sum_q,   out_sum_d;
  logic [W_SUM-1:0]     fin_sum;
  logic [W_DATA-1:0]    sat_val;

  assign fin_sum = st_sum[N_TAPS];
  assign sat_val = (|fin_sum[W_SUM-1:W_DATA]) ? {W_DATA{1'b1}} : fin_sum[W_DATA-1:0];

  always_comb begin
    out_valid_d = st_valid[N_TAPS];
    out_data_d  = out_data_q;
    out_sum_d   = out_sum_q;
    if (st_valid[N_TAPS]) begin
      out_sum_d = fin_sum;
      case (st_mode[N_TAPS])
        AVG:     out_data_d = fin_sum[W_SUM-1:LOG_N];
        SUM_SAT: out_data_d = sat_val;
        MAX:     out_data_d = st_max[N_TAPS];
        PASS:    out_data_d = st_win[N_TAPS][0];
        default: out_data_d = out_data_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sum_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sum_q   <= out_sum_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_fir_avg_pipeline.sv
// tb/tb_fir_avg_pipeline.sv - directed self-checking bench for fir_avg_pipeline (W_DATA=8, N_TAPS=4)
module tb_fir_avg_pipeline;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] mode;
  logic       clear;
  logic       out_valid;
  logic [7:0] out_data;
  logic [9:0] out_sum;
  logic       window_full;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  int acc_q[$];
  int oq_cyc[$];
  int oq_data[$];
  int oq_sum[$];

  always #5 clk = ~clk;

  fir_avg_pipeline #(
    .W_DATA (8),
    .N_TAPS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .mode        (mode),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sum     (out_sum),
    .window_full (window_full)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      oq_cyc.push_back(cyc);
      oq_data.push_back(int'(out_data));
      oq_sum.push_back(int'(out_sum));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic flush_queues();
    acc_q.delete();
    oq_cyc.delete();
    oq_data.delete();
    oq_sum.delete();
  endtask

  task automatic drive(input int d, input int m, input logic c);
    in_valid = 1'b1;
    in_data  = d[7:0];
    mode     = m[1:0];
    clear    = c;
    step();
    acc_q.push_back(cyc);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; in_data = '0; mode = '0;
    idle(2);
    rst = 1'b0;
    flush_queues();
  endtask

  // Waits (bounded) for n results, then a few more cycles to expose extras.
  task automatic drain(input int n);
    for (int i = 0; i < 40 && oq_data.size() < n; i++) step();
    idle(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'd99; mode = 2'd3; clear = 1'b0;
    idle(2);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    vectors++; if (out_data !== 8'd0) begin miscompares++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    vectors++; if (out_sum !== 10'd0) begin miscompares++; $display("FAIL reset_out_sum: got %0d expected 0", out_sum); end
    vectors++; if (window_full !== 1'b0) begin miscompares++; $display("FAIL reset_window_full: got %0b expected 0", window_full); end
    rst = 1'b0; in_valid = 1'b0;
    flush_queues();
    idle(10);
    vectors++; if (oq_data.size() != 0) begin miscompares++; $display("FAIL reset_overrides_in_valid: got %0d strobes expected 0", oq_data.size()); end
  endtask

  task automatic check_results(input string name, input int n, input int exp_d[], input int exp_s[]);
  endtask

  task automatic test_avg_back_to_back();
    int exp_d[4] = '{1, 3, 6, 10};
    int exp_s[4] = '{4, 12, 24, 40};
    int ins[4]   = '{4, 8, 12, 16};
    int gd, gs, gl;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive(ins[i], 0, 1'b0);
      if (i == 2) begin
        vectors++; if (window_full !== 1'b0) begin miscompares++; $display("FAIL avg_full_after3: got %0b expected 0", window_full); end
      end
    end
    vectors++; if (window_full !== 1'b1) begin miscompares++; $display("FAIL avg_full_after4: got %0b expected 1", window_full); end
    drain(4);
    vectors++; if (oq_data.size() != 4) begin miscompares++; $display("FAIL avg_count: got %0d expected 4", oq_data.size()); end
    for (int i = 0; i < 4; i++) begin
      gd = (i < oq_data.size()) ? oq_data[i] : -1;
      gs = (i < oq_sum.size()) ? oq_sum[i] : -1;
      gl = (i < oq_cyc.size()) ? oq_cyc[i] - acc_q[i] : -1;
      vectors++; if (gd != exp_d[i]) begin miscompares++; $display("FAIL avg_data[%0d]: got %0d expected %0d", i, gd, exp_d[i]); end
      vectors++; if (gs != exp_s[i]) begin miscompares++; $display("FAIL avg_sum[%0d]: got %0d expected %0d", i, gs, exp_s[i]); end
      vectors++; if (gl != 5) begin miscompares++; $display("FAIL avg_latency[%0d]: got %0d expected 5", i, gl); end
    end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_valid: got %0b expected 0", out_valid); end
    vectors++; if (out_data !== 8'd10) begin miscompares++; $display("FAIL hold_data: got %0d expected 10", out_data); end
    vectors++; if (out_sum !== 10'd40) begin miscompares++; $display("FAIL hold_sum: got %0d expected 40", out_sum); end
  endtask

  task automatic test_sum_sat();
    int exp_s[4] = '{255, 510, 765, 1020};
    int gd, gs;
    reset_dut();
    for (int i = 0; i < 4; i++) drive(255, 1, 1'b0);
    drain(4);
    vectors++; if (oq_data.size() != 4) begin miscompares++; $display("FAIL sat_count: got %0d expected 4", oq_data.size()); end
    for (int i = 0; i < 4; i++) begin
      gd = (i < oq_data.size()) ? oq_data[i] : -1;
      gs = (i < oq_sum.size()) ? oq_sum[i] : -1;
      vectors++; if (gd != 255) begin miscompares++; $display("FAIL sat_data[%0d]: got %0d expected 255", i, gd); end
      vectors++; if (gs != exp_s[i]) begin miscompares++; $display("FAIL sat_sum[%0d]: got %0d expected %0d", i, gs, exp_s[i]); end
    end
  endtask

  task automatic test_max_pass();
    int ins[5]   = '{3, 200, 7, 9, 1};
    int exp_a[5] = '{3, 200, 200, 200, 200};
    int exp_b[5] = '{3, 200, 200, 200, 1};
    int exp_s[5] = '{3, 203, 210, 219, 217};
    int gd, gs;
    reset_dut();
    for (int i = 0; i < 5; i++) drive(ins[i], 2, 1'b0);
    drain(5);
    vectors++; if (oq_data.size() != 5) begin miscompares++; $display("FAIL max_count: got %0d expected 5", oq_data.size()); end
    for (int i = 0; i < 5; i++) begin
      gd = (i < oq_data.size()) ? oq_data[i] : -1;
      gs = (i < oq_sum.size()) ? oq_sum[i] : -1;
      vectors++; if (gd != exp_a[i]) begin miscompares++; $display("FAIL max_data[%0d]: got %0d expected %0d", i, gd, exp_a[i]); end
      vectors++; if (gs != exp_s[i]) begin miscompares++; $display("FAIL max_sum[%0d]: got %0d expected %0d", i, gs, exp_s[i]); end
    end
    reset_dut();
    for (int i = 0; i < 5; i++) drive(ins[i], (i == 4) ? 3 : 2, 1'b0);
    drain(5);
    for (int i = 0; i < 5; i++) begin
      gd = (i < oq_data.size()) ? oq_data[i] : -1;
      vectors++; if (gd != exp_b[i]) begin miscompares++; $display("FAIL pass_switch_data[%0d]: got %0d expected %0d", i, gd, exp_b[i]); end
    end
  endtask

  task automatic test_gaps();
    int exp_d[4] = '{1, 3, 6, 10};
    int ins[4]   = '{4, 8, 12, 16};
    int gd, gl, gg;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive(ins[i], 0, 1'b0);
      idle(2);
    end
    drain(4);
    vectors++; if (oq_data.size() != 4) begin miscompares++; $display("FAIL gap_count: got %0d expected 4", oq_data.size()); end
    for (int i = 0; i < 4; i++) begin
      gd = (i < oq_data.size()) ? oq_data[i] : -1;
      gl = (i < oq_cyc.size()) ? oq_cyc[i] - acc_q[i] : -1;
      vectors++; if (gd != exp_d[i]) begin miscompares++; $display("FAIL gap_data[%0d]: got %0d expected %0d", i, gd, exp_d[i]); end
      vectors++; if (gl != 5) begin miscompares++; $display("FAIL gap_latency[%0d]: got %0d expected 5", i, gl); end
      if (i > 0) begin
        gg = (i < oq_cyc.size()) ? oq_cyc[i] - oq_cyc[i-1] : -1;
        vectors++; if (gg != 3) begin miscompares++; $display("FAIL gap_spacing[%0d]: got %0d expected 3", i, gg); end
      end
    end
  endtask

  task automatic test_clear();
    int exp_d[8] = '{25, 50, 75, 100, 10, 20, 30, 40};
    int exp_s[8] = '{100, 200, 300, 400, 40, 80, 120, 160};
    int gd, gs;
    reset_dut();
    for (int i = 0; i < 4; i++) drive(100, 0, 1'b0);
    vectors++; if (window_full !== 1'b1) begin miscompares++; $display("FAIL clr_full_before: got %0b expected 1", window_full); end
    drive(40, 0, 1'b1);
    vectors++; if (window_full !== 1'b0) begin miscompares++; $display("FAIL clr_full_after_clear: got %0b expected 0", window_full); end
    drive(40, 0, 1'b0);
    drive(40, 0, 1'b0);
    vectors++; if (window_full !== 1'b0) begin miscompares++; $display("FAIL clr_full_count3: got %0b expected 0", window_full); end
    drive(40, 0, 1'b0);
    vectors++; if (window_full !== 1'b1) begin miscompares++; $display("FAIL clr_full_count4: got %0b expected 1", window_full); end
    drain(8);
    vectors++; if (oq_data.size() != 8) begin miscompares++; $display("FAIL clr_count: got %0d expected 8", oq_data.size()); end
    for (int i = 0; i < 8; i++) begin
      gd = (i < oq_data.size()) ? oq_data[i] : -1;
      gs = (i < oq_sum.size()) ? oq_sum[i] : -1;
      vectors++; if (gd != exp_d[i]) begin miscompares++; $display("FAIL clr_data[%0d]: got %0d expected %0d", i, gd, exp_d[i]); end
      vectors++; if (gs != exp_s[i]) begin miscompares++; $display("FAIL clr_sum[%0d]: got %0d expected %0d", i, gs, exp_s[i]); end
    end
  endtask

  task automatic test_reset_inflight();
    int gd, gs, gl;
    reset_dut();
    drive(50, 0, 1'b0);
    drive(60, 0, 1'b0);
    drive(70, 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    flush_queues();
    idle(10);
    vectors++; if (oq_data.size() != 0) begin miscompares++; $display("FAIL rstfl_strobes: got %0d expected 0", oq_data.size()); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstfl_valid: got %0b expected 0", out_valid); end
    vectors++; if (out_data !== 8'd0) begin miscompares++; $display("FAIL rstfl_data: got %0d expected 0", out_data); end
    vectors++; if (out_sum !== 10'd0) begin miscompares++; $display("FAIL rstfl_sum: got %0d expected 0", out_sum); end
    vectors++; if (window_full !== 1'b0) begin miscompares++; $display("FAIL rstfl_full: got %0b expected 0", window_full); end
    drive(8, 0, 1'b0);
    drain(1);
    gd = (oq_data.size() > 0) ? oq_data[0] : -1;
    gs = (oq_sum.size() > 0) ? oq_sum[0] : -1;
    gl = (oq_cyc.size() > 0) ? oq_cyc[0] - acc_q[0] : -1;
    vectors++; if (oq_data.size() != 1) begin miscompares++; $display("FAIL rstfl_new_count: got %0d expected 1", oq_data.size()); end
    vectors++; if (gd != 2) begin miscompares++; $display("FAIL rstfl_new_data: got %0d expected 2", gd); end
    vectors++; if (gs != 8) begin miscompares++; $display("FAIL rstfl_new_sum: got %0d expected 8", gs); end
    vectors++; if (gl != 5) begin miscompares++; $display("FAIL rstfl_new_latency: got %0d expected 5", gl); end
  endtask

  initial begin
    test_reset();
    test_avg_back_to_back();
    test_sum_sat();
    test_max_pass();
    test_gaps();
    test_clear();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
